// File: rtl/ad396x_pkg.sv
// Shared types for the AD936x front-end emulator.
package ad396x_pkg;

  localparam int AD396X_DATA_WIDTH = 12;

  typedef struct packed {
    logic [AD396X_DATA_WIDTH-1:0] i;
    logic [AD396X_DATA_WIDTH-1:0] q;
  } iq_sample_t;

  typedef enum logic {
    SLOT_I = 1'b0,
    SLOT_Q = 1'b1
  } slot_e;

endpackage

// File: rtl/ad396x_clk_divider.sv
// Port clock generator: divides clk by 2*CLK_DIV, gates only ahead of an I slot,
// and emits single-cycle strobes for the coming rising/falling data_clk edges.
module ad396x_clk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic keep_running_i,
  output logic data_clk_o,
  output logic rise_next_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  if (CLK_DIV < 4) begin : g_bad_clk_div
    $error("ad396x_clk_divider: CLK_DIV must be at least 4");
  end

  logic [DW-1:0] div_q, div_d;
  logic          clk_q, clk_d;
  logic          rise_q;
  logic          run_s;
  logic          wrap_s;

  // Divider advance and data_clk toggle; the low phase is gated only when no pair is in flight.
  always_comb begin
    run_s  = clk_q | en_i | keep_running_i;
    wrap_s = run_s && (div_q == DIV_MAX);
    div_d  = '0;
    clk_d  = clk_q;
    if (wrap_s) begin
      div_d = '0;
      clk_d = ~clk_q;
    end else if (run_s) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = '0;
    end
  end

  // State register for divider, port clock and delayed rise strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      clk_q  <= clk_d;
      rise_q <= wrap_s & ~clk_q;
    end
  end

  assign data_clk_o  = clk_q;
  assign rise_next_o = wrap_s & ~clk_q;
  assign rise_o      = rise_q;
  assign fall_o      = wrap_s & clk_q;

endmodule

// File: rtl/ad396x_frontend_emulator.sv
// AD936x-side emulator of the 1R1T CMOS data port: sends source I/Q as rx slots
// and reassembles tx I/Q pairs from the BBP into a sink stream.
module ad396x_frontend_emulator
  import ad396x_pkg::*;
#(
  parameter int DATA_WIDTH = AD396X_DATA_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] src_i,
  input  logic [DATA_WIDTH-1:0] src_q,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DATA_WIDTH-1:0] sink_i,
  output logic [DATA_WIDTH-1:0] sink_q,
  output logic                  sink_valid,
  output logic                  ad396x_data_clk,
  output logic                  ad396x_rx_frame,
  output logic [DATA_WIDTH-1:0] ad396x_rx_data,
  input  logic                  ad396x_tx_frame,
  input  logic [DATA_WIDTH-1:0] ad396x_tx_data,
  output logic [CNT_WIDTH-1:0]  rx_underruns,
  output logic [CNT_WIDTH-1:0]  tx_frame_errors
);

  if (DATA_WIDTH != AD396X_DATA_WIDTH) begin : g_bad_width
    $error("ad396x_frontend_emulator: DATA_WIDTH must match AD396X_DATA_WIDTH");
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic rise_next_s, rise_s, fall_s;

  slot_e                 slot_q, slot_d;
  logic [DATA_WIDTH-1:0] q_hold_q, q_hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  rx_frame_q, rx_frame_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_WIDTH-1:0]  under_q, under_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_i_q, pend_i_d;
  iq_sample_t            sink_pair_q, sink_pair_d;
  logic                  sink_valid_q, sink_valid_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;

  ad396x_clk_divider #(.CLK_DIV(CLK_DIV)) u_clk_divider (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en),
    .keep_running_i (slot_q == SLOT_Q),
    .data_clk_o     (ad396x_data_clk),
    .rise_next_o    (rise_next_s),
    .rise_o         (rise_s),
    .fall_o         (fall_s)
  );

  assign src_ready = rise_next_s && (slot_q == SLOT_I);

  // Rx slot sequencing, underrun accounting and tx pair reassembly.
  always_comb begin
    slot_d       = slot_q;
    q_hold_d     = q_hold_q;
    hold_valid_d = hold_valid_q;
    rx_frame_d   = rx_frame_q;
    rx_data_d    = rx_data_q;
    under_d      = under_q;
    pend_d       = pend_q;
    pend_i_d     = pend_i_q;
    sink_pair_d  = sink_pair_q;
    sink_valid_d = 1'b0;
    err_d        = err_q;

    if (rise_next_s && (slot_q == SLOT_I)) begin
      slot_d       = SLOT_Q;
      rx_frame_d   = 1'b1;
      hold_valid_d = src_valid;
      rx_data_d    = src_valid ? src_i : '0;
      q_hold_d     = src_valid ? src_q : '0;
    end else if (rise_next_s) begin
      slot_d     = SLOT_I;
      rx_frame_d = 1'b0;
      rx_data_d  = q_hold_q;
    end else begin
      slot_d = slot_q;
    end

    // rise_s lands one cycle after the I slot went out, so rx_frame_q marks it.
    if (rise_s && rx_frame_q && !hold_valid_q) begin
      under_d = sat_inc(under_q);
    end else begin
      under_d = under_q;
    end

    if (fall_s && ad396x_tx_frame) begin
      pend_d   = 1'b1;
      pend_i_d = ad396x_tx_data;
      err_d    = pend_q ? sat_inc(err_q) : err_q;
    end else if (fall_s && pend_q) begin
      pend_d        = 1'b0;
      sink_pair_d.i = pend_i_q;
      sink_pair_d.q = ad396x_tx_data;
      sink_valid_d  = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers for the rx and tx paths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= SLOT_I;
      q_hold_q     <= '0;
      hold_valid_q <= 1'b0;
      rx_frame_q   <= 1'b0;
      rx_data_q    <= '0;
      under_q      <= '0;
      pend_q       <= 1'b0;
      pend_i_q     <= '0;
      sink_pair_q  <= '0;
      sink_valid_q <= 1'b0;
      err_q        <= '0;
    end else begin
      slot_q       <= slot_d;
      q_hold_q     <= q_hold_d;
      hold_valid_q <= hold_valid_d;
      rx_frame_q   <= rx_frame_d;
      rx_data_q    <= rx_data_d;
      under_q      <= under_d;
      pend_q       <= pend_d;
      pend_i_q     <= pend_i_d;
      sink_pair_q  <= sink_pair_d;
      sink_valid_q <= sink_valid_d;
      err_q        <= err_d;
    end
  end

  assign ad396x_rx_frame = rx_frame_q;
  assign ad396x_rx_data  = rx_data_q;
  assign sink_i          = sink_pair_q.i;
  assign sink_q          = sink_pair_q.q;
  assign sink_valid      = sink_valid_q;
  assign rx_underruns    = under_q;
  assign tx_frame_errors = err_q;

endmodule

// File: tb/tb_ad396x_frontend_emulator.sv
// Self-checking bench: frame-position arithmetic model of the port timing plus
// a pair scoreboard for tx capture, with randomized source and tx traffic.
module tb_ad396x_frontend_emulator;

  localparam int DW = 12;
  localparam int CD = 4;

  typedef struct packed {
    bit          frame;
    logic [11:0] data;
  } tx_slot_t;

  typedef struct packed {
    bit          valid;
    logic [11:0] i;
    logic [11:0] q;
  } src_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en = 1'b0;
  logic [DW-1:0] src_i = '0, src_q = '0;
  logic          src_valid = 1'b0;
  logic          tx_frame = 1'b0;
  logic [DW-1:0] tx_data = '0;

  logic          src_ready, sink_valid, dclk, rx_frame;
  logic [DW-1:0] sink_i, sink_q, rx_data;
  logic [15:0]   under, err;

  logic          src_ready2, sink_valid2, dclk2, rx_frame2;
  logic [DW-1:0] sink_i2, sink_q2, rx_data2;
  logic [1:0]    under2, err2;

  always #5 clk = ~clk;

  ad396x_frontend_emulator #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .src_i(src_i), .src_q(src_q),
    .src_valid(src_valid), .src_ready(src_ready), .sink_i(sink_i), .sink_q(sink_q),
    .sink_valid(sink_valid), .ad396x_data_clk(dclk), .ad396x_rx_frame(rx_frame),
    .ad396x_rx_data(rx_data), .ad396x_tx_frame(tx_frame), .ad396x_tx_data(tx_data),
    .rx_underruns(under), .tx_frame_errors(err)
  );

  ad396x_frontend_emulator #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .src_i(src_i), .src_q(src_q),
    .src_valid(src_valid), .src_ready(src_ready2), .sink_i(sink_i2), .sink_q(sink_q2),
    .sink_valid(sink_valid2), .ad396x_data_clk(dclk2), .ad396x_rx_frame(rx_frame2),
    .ad396x_rx_data(rx_data2), .ad396x_tx_frame(tx_frame), .ad396x_tx_data(tx_data),
    .rx_underruns(under2), .tx_frame_errors(err2)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  tx_slot_t    tx_plan[$];
  src_t        src_plan[$];
  tx_slot_t    tx_cur;
  int          n;
  bit          nxt_v;
  logic [11:0] nxt_i, nxt_q, cur_i, cur_q;
  int          exp_under, exp_err;
  bit          pend, exp_sv;
  logic [11:0] pend_i, exp_si, exp_sq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    n = 0; nxt_v = 1'b0; nxt_i = '0; nxt_q = '0; cur_i = '0; cur_q = '0;
    exp_under = 0; exp_err = 0; pend = 1'b0; exp_sv = 1'b0;
    pend_i = '0; exp_si = '0; exp_sq = '0; tx_cur = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, {28'd0, dclk, rx_frame, rx_data, src_ready, sink_i, sink_q, sink_valid}, 64'd0);
    chk({tag, "_b"}, {32'd0, under, err}, 64'd0);
    chk({tag, "_c"}, {20'd0, dclk2, rx_frame2, rx_data2, src_ready2, sink_i2, sink_q2,
                      sink_valid2, under2, err2}, 64'd0);
  endtask

  // One port cycle per iteration: drive, predict, advance, compare.
  task automatic run_cycles(input int cycles);
    src_t s;
    int   m;
    for (int c = 0; c < cycles; c++) begin
      src_i     = 12'($urandom);
      src_q     = 12'($urandom);
      src_valid = 1'($urandom_range(0, 1));
      if (n % 16 == 3) begin
        if (src_plan.size() > 0) s = src_plan.pop_front();
        else s = {1'($urandom_range(0, 3) != 0), 12'($urandom), 12'($urandom)};
        src_valid = s.valid; src_i = s.i; src_q = s.q;
        nxt_v = s.valid;
        nxt_i = s.valid ? s.i : 12'h000;
        nxt_q = s.valid ? s.q : 12'h000;
      end
      if (n % 8 == 4) begin
        if (tx_plan.size() > 0) tx_cur = tx_plan.pop_front();
        else tx_cur = {1'($urandom_range(0, 1)), 12'($urandom)};
        tx_frame = tx_cur.frame; tx_data = tx_cur.data;
      end
      exp_sv = 1'b0;
      if (n % 8 == 7) begin
        if (tx_cur.frame) begin
          if (pend) exp_err = sat16(exp_err + 1);
          pend = 1'b1; pend_i = tx_cur.data;
        end else if (pend) begin
          exp_sv = 1'b1; exp_si = pend_i; exp_sq = tx_cur.data; pend = 1'b0;
        end
      end
      chk("src_ready", src_ready, (n % 16 == 3));
      @(posedge clk); #1; n++;
      if (n >= 4 && (n - 4) % 16 == 0) begin
        cur_i = nxt_i; cur_q = nxt_q;
        if (!nxt_v) exp_under++;
      end
      chk("data_clk", dclk, (n / 4) % 2);
      m = (n >= 4) ? (n - 4) % 16 : -1;
      chk("rx_frame", rx_frame, (m >= 0 && m < 8));
      chk("rx_data", rx_data, (m < 0) ? 12'h000 : ((m < 8) ? cur_i : cur_q));
      chk("sink_valid", sink_valid, exp_sv);
      chk("sink_iq", {sink_i, sink_q}, {exp_si, exp_sq});
      chk("tx_frame_errors", err, exp_err);
      chk("tx_frame_errors_sat", err2, sat3(exp_err));
      if (m == 8) begin
        chk("rx_underruns", under, exp_under);
        chk("rx_underruns_sat", under2, sat3(exp_under));
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();

    // Reset held while inputs toggle.
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      en = 1'($urandom_range(0, 1)); src_valid = ~src_valid; tx_frame = ~tx_frame;
      tx_data = 12'hAAA; src_i = 12'hAAA; src_q = 12'hAAA;
      check_all_zero("reset_hold");
    end

    // Directed head of the traffic, then random traffic.
    src_plan.push_back({1'b1, 12'h0F0, 12'h30C});
    for (int k = 0; k < 5; k++) src_plan.push_back({1'b0, 12'h000, 12'h000});
    tx_plan.push_back({1'b0, 12'h123});
    tx_plan.push_back({1'b1, 12'hAAA});
    tx_plan.push_back({1'b0, 12'h555});
    tx_plan.push_back({1'b1, 12'h111});
    tx_plan.push_back({1'b1, 12'h222});
    tx_plan.push_back({1'b0, 12'h333});

    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1; tx_frame = 1'b0; tx_data = '0;
    model_reset();
    run_cycles(480);
    chk("underruns_saturated", under2, 2'd3);

    // Leave an I pending, then reset asynchronously mid-pair.
    tx_plan.push_back({1'b1, 12'h4C4});
    run_cycles(10);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_all_zero("reset_mid");
    end

    tx_plan.push_back({1'b0, 12'h777});
    tx_plan.push_back({1'b1, 12'h1A5});
    tx_plan.push_back({1'b0, 12'h5A1});
    rst_n = 1'b1; en = 1'b1; tx_frame = 1'b0; tx_data = '0;
    model_reset();
    run_cycles(77);

    // Drop en in the Q high phase: the slot finishes, then the clock parks low.
    en = 1'b0;
    src_valid = 1'b1;
    tx_frame = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk("gated_src_ready", src_ready, 1'b0);
      @(posedge clk); #1; n++;
      chk("gated_data_clk", dclk, (c < 2));
      chk("gated_rx_frame", rx_frame, 1'b0);
      chk("gated_rx_data", rx_data, cur_q);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ad396x_frontend_emulator.md
Name: ad396x_frontend_emulator

Overview:
- Synthesizable stand-in for the AD936x chip side of the 1R1T 12-bit CMOS data port. Drives the opposite end of the BBP data interface.
- Generates `ad396x_data_clk`.
- Drives `ad396x_rx_frame`/`ad396x_rx_data` from an I/Q stream source.
- Captures `ad396x_tx_frame`/`ad396x_tx_data` into an I/Q stream sink.
- Used for closed-loop bring-up and for benches of the BBP-side interface without RF hardware.

Parameters:
- DATA_WIDTH, 12, width of I, Q and the port data bus.
- CLK_DIV, 4, `clk` cycles per `data_clk` half-period. Must be ≥4; elaboration error otherwise.
- CNT_WIDTH, 16, width of the saturating status counters.

Ports:
- clk  in  1  system clock; the only clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enable for `data_clk` generation.
- src_i  in  DATA_WIDTH  I sample to transmit on the rx port.
- src_q  in  DATA_WIDTH  Q sample to transmit on the rx port.
- src_valid  in  1  source sample valid.
- src_ready  out  1  one-cycle pulse; a transfer occurs when it coincides with src_valid.
- sink_i  out  DATA_WIDTH  captured I.
- sink_q  out  DATA_WIDTH  captured Q.
- sink_valid  out  1  one-cycle pulse per captured pair; there is no backpressure.
- ad396x_data_clk  out  1  generated port clock, 50% duty.
- ad396x_rx_frame  out  1  high during the I slot, low during the Q slot.
- ad396x_rx_data  out  DATA_WIDTH  rx slot data.
- ad396x_tx_frame  in  1  tx frame from the BBP.
- ad396x_tx_data  in  DATA_WIDTH  tx data from the BBP.
- rx_underruns  out  CNT_WIDTH  saturating count of frames sent without source data.
- tx_frame_errors  out  CNT_WIDTH  saturating count of I slots received while an I was already pending.

Behaviour:

Reset:
- All outputs are 0 while rst_n=0: data_clk, rx_frame, rx_data, src_ready, sink_*, and both counters.
- Internal state after reset: divider=0, slot=I, pending_i cleared.

Clock generation:
- The divider counts 0..CLK_DIV-1 while `data_clk` is high, or while it is low and en=1.
- On wrap, `data_clk` toggles (registered output).
- With en=0 and `data_clk` low, the divider holds at 0.
- With en=0 during a high phase, the high phase completes.
- A started I/Q pair always completes: with en=0 in the Q-slot low phase... gating applies only at the low phase preceding an I slot. Otherwise the clock keeps running until the Q slot is sent.
- First rising edge occurs CLK_DIV cycles after rst_n release with en=1. Period is 2*CLK_DIV.

Rx slot FSM (states SLOT_I, SLOT_Q), advanced on each `data_clk` rising edge:
- rx_frame/rx_data update on the same clk edge that raises `data_clk`.
- SLOT_I: rx_frame=1, rx_data=held I.
- SLOT_Q: rx_frame=0, rx_data=held Q.
- Values are held for the full 2*CLK_DIV-cycle slot.

Source handshake:
- src_ready=1 for exactly the one cycle before an SLOT_I rising edge (divider=CLK_DIV-1, `data_clk` low, next slot I).
- If src_valid=1 in that cycle: I/Q are latched into a hold register and sent in the following frame.
- Otherwise: zeros are sent, rx_frame still toggles, and rx_underruns += 1, saturating at all-ones.
- The source must not change I/Q mid-frame from the port's point of view: the hold register isolates them.

Tx capture:
- The sample point is the clk edge that drives `data_clk` 1→0; tx_frame/tx_data are registered there.
- Frame=1, no pending I: store I, set pending_i.
- Frame=1 with pending_i: overwrite I and increment tx_frame_errors (saturating).
- Frame=0 with pending_i: sink_i/sink_q update and sink_valid pulses for one cycle, registered on the same edge as the sample; pending_i is cleared.
- Frame=0 without pending_i: ignored (unsynchronised; no error).
- sink_i/sink_q hold their value between pulses.

Other conditions:
- Reset mid-frame: everything returns to reset values immediately (asynchronous); a partial pair is discarded.
- Simultaneous src handshake and tx sample cannot collide; the paths are independent.

Decomposition:
- Package ad396x_pkg:
  - localparam AD396X_DATA_WIDTH=12.
  - typedef iq_sample_t (struct of i, q at DATA_WIDTH).
  - enum slot_e {SLOT_I, SLOT_Q}.
- Sub-module ad396x_clk_divider: divider, en gating, and registered data_clk. Outputs one-cycle rise_next, rise and fall strobes used by the rx and tx paths.
- Rx FSM and tx capture stay in the top.

Test Plan (CLK_DIV=4):
1. Reset held 1000 cycles while toggling en/src_valid/tx inputs with data 0xAAA -> every output stays 0.
2. Release reset with en=1 -> data_clk first rises at cycle 4, period 8, duty 4/4. Drop en mid-Q slot -> clock stops low only after the Q slot ends.
3. src_valid=1, I=0x0F0, Q=0x30C -> rx_frame=1 and rx_data=0x0F0 for 8 cycles from the rising edge, then rx_frame=0 and rx_data=0x30C for 8 cycles. src_ready pulses once every 16 cycles. Changing src_i mid-frame does not alter rx_data.
4. src_valid=0 for 3 frames -> rx_data=0, rx_frame still alternates, rx_underruns=3. Preloading saturation (CNT_WIDTH=2, 5 frames) -> counter holds at 3.
5. Drive tx_frame=1/data=0xAAA, then frame=0/data=0x555 stable around consecutive falling edges -> one sink_valid pulse with sink_i=0xAAA, sink_q=0x555. A leading lone frame=0 slot is ignored with no error.
6. Two consecutive frame=1 slots (0x111, 0x222) then frame=0 (0x333) -> tx_frame_errors=1, sink_i=0x222, sink_q=0x333. Assert rst_n=0 mid-pair -> all outputs 0 immediately and no sink_valid on restart until a fresh I/Q pair.
